div_u16x8: RTL and testbench

DIV_U16X8 -- requirements
Module: div_u16x8

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 27 ++
 rtl/div_u16x8.sv | 123 ++++++++++++
 tb/tb_div_u16x8.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the 16-by-8 unsigned sequential divider.
// Holds the operand/result widths, the iteration count and the
// controller state encoding used by div_u16x8.
package div_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int ITERS      = 16;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
//   rem_i     : 9-bit partial remainder before this step (always < divisor)
//   bit_i     : next dividend bit, MSB first
//   divisor_i : 8-bit divisor
//   rem_o     : partial remainder after shift / conditional subtract
//   q_o       : quotient bit produced by this step
module div_step
  import div_pkg::*;
(
  input  logic [DIVISOR_W:0]   rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   rem_o,
  output logic                 q_o
);

  logic [DIVISOR_W:0] shifted;
  logic [DIVISOR_W:0] diff;

  // rem_i is always below the divisor, so its top bit is zero and the
  // left shift cannot lose information; the shifted value needs 9 bits.
  assign shifted = {rem_i[DIVISOR_W-1:0], bit_i};
  assign diff    = shifted - {1'b0, divisor_i};
  assign q_o     = (shifted >= {1'b0, divisor_i});
  assign rem_o   = q_o ? diff : shifted;

endmodule

// File: rtl/div_u16x8.sv
// Sequential unsigned divider: 16-bit dividend / 8-bit divisor, one
// restoring step per clock.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request, accepted while busy is low
//   dividend    : 16-bit operand, captured on accept
//   divisor     : 8-bit operand, captured on accept
//   busy        : high while iterating (RUN state)
//   done        : one-cycle pulse when a new result is presented
//   quotient    : 16-bit result, held until the next done
//   remainder   : 8-bit result, held alongside quotient
//   div_by_zero : set when the latest result came from a zero divisor
// A zero divisor skips iteration entirely and reports
// quotient=FFFF, remainder=dividend[7:0].
module div_u16x8
  import div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [DIVISOR_W:0]    rem_q;
  // Holds the dividend; quotient bits are shifted in from the LSB as the
  // dividend bits leave from the MSB, so after 16 steps it is the quotient.
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [DIVIDEND_W-1:0] quot_q;
  logic [DIVISOR_W-1:0]  rem_out_q;
  logic                  dbz_q;
  logic                  done_q;

  logic                  accept;
  logic                  last_iter;
  logic [DIVISOR_W:0]    rem_next;
  logic                  q_bit;

  div_step u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[DIVIDEND_W-1]),
    .divisor_i (dvs_q),
    .rem_o     (rem_next),
    .q_o       (q_bit)
  );

  assign accept    = start && (state_q != RUN);
  assign last_iter = (cnt_q == CNT_W'(ITERS - 1));

  // NOTE: every variable assigned in always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) state_d = (divisor == '0) ? DONE : RUN;
        else        state_d = IDLE;
      end
      RUN: begin
        if (last_iter) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      quot_q    <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == DONE);

      if (accept) begin
        dvd_q <= dividend;
        dvs_q <= divisor;
        rem_q <= '0;
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        dvd_q <= {dvd_q[DIVIDEND_W-2:0], q_bit};
        rem_q <= rem_next;
        cnt_q <= cnt_q + CNT_W'(1);
      end

      // Results change only on the edge that enters DONE. Entering DONE
      // together with an accept can only mean a zero divisor.
      if (state_d == DONE) begin
        if (accept) begin
          quot_q    <= '1;
          rem_out_q <= dividend[DIVISOR_W-1:0];
          dbz_q     <= 1'b1;
        end else begin
          quot_q    <= {dvd_q[DIVIDEND_W-2:0], q_bit};
          rem_out_q <= rem_next[DIVISOR_W-1:0];
          dbz_q     <= 1'b0;
        end
      end
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_u16x8.sv
// Directed self-checking bench for div_u16x8.
module tb_div_u16x8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int n_asserts = 0;
  int n_fails   = 0;

  div_u16x8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request, wait for done (bounded), then check latency and results.
  // Latency is the number of edges after the accepting edge until done is seen.
  task automatic do_div(input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] exp_q, input logic [7:0] exp_r,
                        input logic exp_dbz, input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check(lat, exp_lat, {tag, "_latency"});
    check(quotient, exp_q, {tag, "_quotient"});
    check(remainder, exp_r, {tag, "_remainder"});
    check(div_by_zero, exp_dbz, {tag, "_dbz"});
  endtask

  initial begin
    int lat;
    int done_seen;
    logic [7:0]  sw_dvs [10];
    logic [15:0] sw_dvd [8];

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check(busy, 0, "reset_busy");
    check(done, 0, "reset_done");
    check(quotient, 0, "reset_quotient");
    check(remainder, 0, "reset_remainder");
    check(div_by_zero, 0, "reset_dbz");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic case, with busy checked right after accept.
    @(negedge clk);
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check(busy, 1, "d1000_busy");
    check(done, 0, "d1000_no_early_done");
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check(lat, 16, "d1000_latency");
    check(quotient, 16'd142, "d1000_quotient");
    check(remainder, 8'd6, "d1000_remainder");
    check(div_by_zero, 0, "d1000_dbz");
    check(busy, 0, "d1000_busy_in_done");
    @(posedge clk);
    #1;
    check(done, 0, "d1000_done_single_pulse");
    check(quotient, 16'd142, "d1000_quotient_held");

    // Range boundaries.
    do_div(16'hFFFF, 8'd1,   16'hFFFF, 8'd0,   1'b0, 16, "d65535_1");
    do_div(16'd254,  8'd255, 16'd0,    8'd254, 1'b0, 16, "d254_255");

    // Zero divisor: DONE entered on the accepting edge.
    do_div(16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b1, 0, "dz_1234");
    // Flag clears on the next normal result.
    do_div(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16, "d1000_after_dz");

    // Back-to-back: new start in the done cycle of 100/3.
    @(negedge clk);
    dividend = 16'd100;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check(lat, 16, "b2b_first_latency");
    check(quotient, 16'd33, "b2b_first_quotient");
    check(remainder, 8'd1, "b2b_first_remainder");
    dividend = 16'd200;
    divisor  = 8'd9;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check(busy, 1, "b2b_second_accepted");
    check(done, 0, "b2b_done_dropped");
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check(lat, 16, "b2b_second_latency");
    check(quotient, 16'd22, "b2b_second_quotient");
    check(remainder, 8'd2, "b2b_second_remainder");

    // Asynchronous reset in the middle of 5000/13.
    @(negedge clk);
    dividend = 16'd5000;
    divisor  = 8'd13;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check(busy, 0, "rst_mid_busy");
    check(done, 0, "rst_mid_done");
    check(quotient, 0, "rst_mid_quotient");
    check(remainder, 0, "rst_mid_remainder");
    check(div_by_zero, 0, "rst_mid_dbz");
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check(done_seen, 0, "rst_mid_no_done");

    // First start after reset accepted immediately; start toggles and
    // operand changes during RUN must not disturb the result.
    @(negedge clk);
    dividend = 16'd5000;
    divisor  = 8'd13;
    start    = 1'b1;
    @(posedge clk);
    #1;
    check(busy, 1, "post_rst_accept");
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      start    = ~start;
      dividend = 16'(lat * 977 + 3);
      divisor  = 8'(lat * 31 + 1);
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check(lat, 16, "toggle_latency");
    check(quotient, 16'd384, "toggle_quotient");
    check(remainder, 8'd8, "toggle_remainder");

    // Sampled sweep across divisor and dividend corners.
    sw_dvs = '{8'd1, 8'd2, 8'd3, 8'd7, 8'd16, 8'd100, 8'd128, 8'd200, 8'd254, 8'd255};
    sw_dvd = '{16'd0, 16'd1, 16'd255, 16'd256, 16'h7FFF, 16'h8000, 16'hFFFF, 16'd12345};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 8; j++) begin
        do_div(sw_dvd[j], sw_dvs[i], sw_dvd[j] / 16'(sw_dvs[i]),
               8'(sw_dvd[j] % 16'(sw_dvs[i])), 1'b0, 16,
               $sformatf("sweep_%0d_by_%0d", sw_dvd[j], sw_dvs[i]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
